// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, EXT and memory-side bundle of the data memory arbiter.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              start_i;

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_stall_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_done_o;

  logic              ext_valid_i;
  logic              ext_ready_o;
  logic              ext_we_i;
  logic [ADDR_W-1:0] ext_addr_i;
  logic [DATA_W-1:0] ext_wdata_i;
  logic              ext_rvalid_o;
  logic [DATA_W-1:0] ext_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  start_i,
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_stall_o, cpu_rdata_o, cpu_done_o,
    input  ext_valid_i, ext_we_i, ext_addr_i, ext_wdata_i,
    output ext_ready_o, ext_rvalid_o, ext_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output start_i,
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_stall_o, cpu_rdata_o, cpu_done_o,
    output ext_valid_i, ext_we_i, ext_addr_i, ext_wdata_i,
    input  ext_ready_o, ext_rvalid_o, ext_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the multi-cycle data memory between MEM stage and EXT port.
// Define DMEM_ARB_RR_EN for round-robin ties; default is CPU-first priority.
module dmem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic grant_cpu;
  logic grant_ext;
  logic grant;

`ifdef DMEM_ARB_RR_EN
  owner_t last_q;

  // Tie goes to whichever port was not granted last.
  always_comb begin
    grant_cpu = 1'b0;
    grant_ext = 1'b0;
    if (bus.cpu_req_i && bus.ext_valid_i) begin
      grant_cpu = (last_q == OWN_EXT);
      grant_ext = (last_q == OWN_CPU);
    end else begin
      grant_cpu = bus.cpu_req_i;
      grant_ext = bus.ext_valid_i;
    end
  end

  // Remember the port of the most recent grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= OWN_EXT;
    end else if (state_q == IDLE && bus.start_i && grant) begin
      last_q <= grant_ext ? OWN_EXT : OWN_CPU;
    end
  end
`else
  // CPU always wins; EXT only when the CPU is quiet.
  always_comb begin
    grant_cpu = bus.cpu_req_i;
    grant_ext = bus.ext_valid_i && !bus.cpu_req_i;
  end
`endif

  assign grant = grant_cpu || grant_ext;

  // Next-state, latched request and read-data capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && grant) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          if (grant_ext) begin
            owner_d = OWN_EXT;
            we_d    = bus.ext_we_i;
            addr_d  = bus.ext_addr_i;
            wdata_d = bus.ext_wdata_i;
          end else begin
            owner_d = OWN_CPU;
            we_d    = bus.cpu_we_i;
            addr_d  = bus.cpu_addr_i;
            wdata_d = bus.cpu_wdata_i;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          if (!we_q) begin
            if (owner_q == OWN_CPU) begin
              cpu_rdata_d = bus.mem_rdata_i;
            end else begin
              ext_rdata_d = bus.mem_rdata_i;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // Handshake and memory-bus outputs; request-driven ones forced low in reset.
  always_comb begin
    bus.ext_ready_o  = rst_i && (state_q == IDLE)
                       && bus.start_i && grant_ext;
    bus.cpu_stall_o  = rst_i && bus.start_i && bus.cpu_req_i
                       && !(state_q == DONE && owner_q == OWN_CPU);
    bus.cpu_done_o   = (state_q == DONE) && (owner_q == OWN_CPU);
    bus.ext_rvalid_o = (state_q == DONE) && (owner_q == OWN_EXT);
    bus.cpu_rdata_o  = cpu_rdata_q;
    bus.ext_rdata_o  = ext_rdata_q;
    bus.mem_en_o     = (state_q == BUSY) && (cnt_q == CNT_INIT);
    bus.mem_we_o     = we_q;
    bus.mem_addr_o   = addr_q;
    bus.mem_wdata_o  = wdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the data memory arbiter.
// Memory model returns fixed words for a few addresses.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .MEM_LAT(2),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h30:  return 32'hCAFEF00D;
      32'h40:  return 32'h11110040;
      32'h44:  return 32'h22220044;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.mem_rdata_i = mem_model(bus.mem_addr_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b1;
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = 32'h10;
    bus.cpu_wdata_i = '0;
    bus.ext_valid_i = 1'b1;
    bus.ext_we_i = 1'b0;
    bus.ext_addr_i = 32'h30;
    bus.ext_wdata_i = '0;
    #3;
    checks++;
    if ({bus.cpu_stall_o, bus.ext_ready_o, bus.mem_en_o, bus.mem_we_o,
         bus.cpu_done_o, bus.ext_rvalid_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.cpu_stall_o, bus.ext_ready_o, bus.mem_en_o,
                bus.mem_we_o, bus.cpu_done_o, bus.ext_rvalid_o});
    end
    checks++;
    if ({bus.mem_addr_o, bus.cpu_rdata_o, bus.ext_rdata_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0", bus.mem_addr_o,
               bus.cpu_rdata_o, bus.ext_rdata_o);
    end
    bus.cpu_req_i = 1'b0;
    bus.ext_valid_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_load();
    int n_stall = 0;
    int n_en = 0;
    int n_done = 0;
    int done_at = -1;
    logic [31:0] rd = '0;
    logic [31:0] en_addr = '0;
    bit drop = 0;
    step();
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = 32'h10;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
        if (drop) bus.cpu_req_i = 1'b0;
      end
      #1;
      if (bus.cpu_stall_o) n_stall++;
      if (bus.mem_en_o) begin n_en++; en_addr = bus.mem_addr_o; end
      if (bus.cpu_done_o) begin
        n_done++; done_at = i; rd = bus.cpu_rdata_o; drop = 1;
      end
    end
    checks++;
    if (n_stall !== 3) begin
      errors++; $display("FAIL load_stall got %0d want 3", n_stall);
    end
    checks++;
    if (n_en !== 1) begin
      errors++; $display("FAIL load_en_count got %0d want 1", n_en);
    end
    checks++;
    if (en_addr !== 32'h10) begin
      errors++; $display("FAIL load_addr got %h want 00000010", en_addr);
    end
    checks++;
    if (n_done !== 1 || done_at !== 3) begin
      errors++;
      $display("FAIL load_done got n=%0d at=%0d want n=1 at=3", n_done, done_at);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_rdata got %h want deadbeef", rd);
    end
  endtask

  task automatic test_ext_write();
    int n_ready = 0;
    int ready_at = -1;
    int n_we = 0;
    int n_rv = 0;
    int rv_at = -1;
    int n_stall = 0;
    logic [31:0] wd = '0;
    logic [31:0] erd = 32'hFFFFFFFF;
    bit acc = 0;
    step();
    bus.ext_valid_i = 1'b1;
    bus.ext_we_i = 1'b1;
    bus.ext_addr_i = 32'h20;
    bus.ext_wdata_i = 32'h5A5A5A5A;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
        if (acc) bus.ext_valid_i = 1'b0;
      end
      #1;
      if (bus.ext_ready_o) begin n_ready++; ready_at = i; acc = 1; end
      if (bus.mem_we_o) begin n_we++; wd = bus.mem_wdata_o; end
      if (bus.cpu_stall_o) n_stall++;
      if (bus.ext_rvalid_o) begin n_rv++; rv_at = i; erd = bus.ext_rdata_o; end
    end
    checks++;
    if (n_ready !== 1 || ready_at !== 0) begin
      errors++;
      $display("FAIL ext_ready got n=%0d at=%0d want n=1 at=0", n_ready, ready_at);
    end
    checks++;
    if (n_we !== 2) begin
      errors++; $display("FAIL ext_we_cycles got %0d want 2", n_we);
    end
    checks++;
    if (wd !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL ext_wdata got %h want 5a5a5a5a", wd);
    end
    checks++;
    if (n_rv !== 1 || rv_at !== 3) begin
      errors++;
      $display("FAIL ext_rvalid got n=%0d at=%0d want n=1 at=3", n_rv, rv_at);
    end
    checks++;
    if (erd !== 32'h0) begin
      errors++; $display("FAIL ext_write_rdata got %h want 0", erd);
    end
    checks++;
    if (n_stall !== 0) begin
      errors++; $display("FAIL ext_cpu_stall got %0d want 0", n_stall);
    end
    bus.ext_we_i = 1'b0;
  endtask

  task automatic test_tie();
    int n_en = 0;
    int en_at[4];
    logic [31:0] en_a[4];
    int ready_at = -1;
    int done_at = -1;
    int rv_at = -1;
    logic [31:0] crd = '0;
    logic [31:0] erd = '0;
    bit cdrop = 0;
    bit eacc = 0;
    for (int k = 0; k < 4; k++) begin en_at[k] = -1; en_a[k] = '0; end
    step();
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = 32'h40;
    bus.ext_valid_i = 1'b1;
    bus.ext_we_i = 1'b0;
    bus.ext_addr_i = 32'h44;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        step();
`ifdef DMEM_ARB_RR_EN
        if (cdrop) begin bus.cpu_addr_i = 32'h10; cdrop = 0; end
        if (eacc) begin bus.ext_addr_i = 32'h30; eacc = 0; end
`else
        if (cdrop) bus.cpu_req_i = 1'b0;
        if (eacc) bus.ext_valid_i = 1'b0;
`endif
      end
      #1;
      if (bus.mem_en_o) begin
        if (n_en < 4) begin en_at[n_en] = i; en_a[n_en] = bus.mem_addr_o; end
        n_en++;
      end
      if (bus.ext_ready_o && ready_at < 0) begin ready_at = i; eacc = 1; end
      if (bus.cpu_done_o && done_at < 0) begin
        done_at = i; crd = bus.cpu_rdata_o; cdrop = 1;
      end
      if (bus.ext_rvalid_o && rv_at < 0) begin rv_at = i; erd = bus.ext_rdata_o; end
    end
`ifdef DMEM_ARB_RR_EN
    checks++;
    if (n_en !== 3) begin
      errors++; $display("FAIL rr_en_count got %0d want 3", n_en);
    end
    checks++;
    if (en_a[0] !== 32'h40 || en_a[1] !== 32'h44 || en_a[2] !== 32'h10) begin
      errors++;
      $display("FAIL rr_order got %h %h %h want 40 44 10",
               en_a[0], en_a[1], en_a[2]);
    end
    checks++;
    if (en_at[0] !== 1 || en_at[1] !== 5 || en_at[2] !== 9) begin
      errors++;
      $display("FAIL rr_en_cycles got %0d %0d %0d want 1 5 9",
               en_at[0], en_at[1], en_at[2]);
    end
    checks++;
    if (ready_at !== 4 || erd !== 32'h22220044) begin
      errors++;
      $display("FAIL rr_ext got at=%0d data=%h want at=4 data=22220044",
               ready_at, erd);
    end
    bus.cpu_req_i = 1'b0;
    bus.ext_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
`else
    checks++;
    if (n_en !== 2 || en_a[0] !== 32'h40 || en_a[1] !== 32'h44) begin
      errors++;
      $display("FAIL tie_order got n=%0d %h %h want n=2 40 44",
               n_en, en_a[0], en_a[1]);
    end
    checks++;
    if (en_at[0] !== 1 || en_at[1] !== 5) begin
      errors++;
      $display("FAIL tie_en_cycles got %0d %0d want 1 5", en_at[0], en_at[1]);
    end
    checks++;
    if (done_at !== 3 || crd !== 32'h11110040) begin
      errors++;
      $display("FAIL tie_cpu got at=%0d data=%h want at=3 data=11110040",
               done_at, crd);
    end
    checks++;
    if (ready_at !== 4) begin
      errors++; $display("FAIL tie_ext_ready got %0d want 4", ready_at);
    end
    checks++;
    if (rv_at !== 7 || erd !== 32'h22220044) begin
      errors++;
      $display("FAIL tie_ext_rvalid got at=%0d data=%h want at=7 data=22220044",
               rv_at, erd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n_en = 0;
    int n_done = 0;
    int done_at[2];
    logic [31:0] en_a[2];
    logic [31:0] rd[2];
    bit chg = 0;
    for (int k = 0; k < 2; k++) begin
      done_at[k] = -1; en_a[k] = '0; rd[k] = '0;
    end
    step();
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = 32'h40;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        step();
        if (chg) begin
          if (n_done == 1) bus.cpu_addr_i = 32'h44;
          else bus.cpu_req_i = 1'b0;
          chg = 0;
        end
      end
      #1;
      if (bus.mem_en_o) begin
        if (n_en < 2) en_a[n_en] = bus.mem_addr_o;
        n_en++;
      end
      if (bus.cpu_done_o) begin
        if (n_done < 2) begin done_at[n_done] = i; rd[n_done] = bus.cpu_rdata_o; end
        n_done++;
        chg = 1;
      end
    end
    checks++;
    if (n_en !== 2) begin
      errors++; $display("FAIL b2b_en_count got %0d want 2", n_en);
    end
    checks++;
    if (en_a[0] !== 32'h40 || en_a[1] !== 32'h44) begin
      errors++;
      $display("FAIL b2b_addr got %h %h want 40 44", en_a[0], en_a[1]);
    end
    checks++;
    if (n_done !== 2 || done_at[0] !== 3 || done_at[1] !== 7) begin
      errors++;
      $display("FAIL b2b_done got n=%0d at %0d %0d want n=2 at 3 7",
               n_done, done_at[0], done_at[1]);
    end
    checks++;
    if (rd[0] !== 32'h11110040 || rd[1] !== 32'h22220044) begin
      errors++;
      $display("FAIL b2b_rdata got %h %h want 11110040 22220044", rd[0], rd[1]);
    end
  endtask

  task automatic test_reset_mid_busy();
    int n_rv = 0;
    int done_at = -1;
    logic [31:0] rd = '0;
    bit drop = 0;
    step();
    bus.ext_valid_i = 1'b1;
    bus.ext_we_i = 1'b0;
    bus.ext_addr_i = 32'h30;
    step();
    bus.ext_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h30) begin
      errors++;
      $display("FAIL rst_pre_busy got en=%b addr=%h want en=1 addr=30",
               bus.mem_en_o, bus.mem_addr_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_en_o, bus.mem_we_o, bus.ext_rvalid_o, bus.ext_ready_o,
         bus.cpu_done_o, bus.cpu_stall_o} !== 6'b0 || bus.mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got en=%b addr=%h want 0",
               bus.mem_en_o, bus.mem_addr_o);
    end
    checks++;
    if (bus.cpu_rdata_o !== 32'h0 || bus.ext_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_rdata got %h %h want 0 0",
               bus.cpu_rdata_o, bus.ext_rdata_o);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      if (bus.ext_rvalid_o) n_rv++;
    end
    checks++;
    if (n_rv !== 0) begin
      errors++; $display("FAIL rst_no_rvalid got %0d want 0", n_rv);
    end
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = 32'h10;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        step();
        if (drop) bus.cpu_req_i = 1'b0;
      end
      #1;
      if (bus.cpu_done_o && done_at < 0) begin
        done_at = i; rd = bus.cpu_rdata_o; drop = 1;
      end
    end
    checks++;
    if (done_at !== 3 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_after_cpu got at=%0d data=%h want at=3 data=deadbeef",
               done_at, rd);
    end
  endtask

  task automatic test_start_gate();
    int n_en = 0;
    int n_ready = 0;
    int n_stall = 0;
    int done_at = -1;
    bit drop = 0;
    step();
    bus.start_i = 1'b0;
    bus.cpu_req_i = 1'b1;
    bus.cpu_addr_i = 32'h40;
    bus.ext_valid_i = 1'b1;
    bus.ext_addr_i = 32'h44;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      if (bus.mem_en_o) n_en++;
      if (bus.ext_ready_o) n_ready++;
      if (bus.cpu_stall_o) n_stall++;
    end
    checks++;
    if (n_en !== 0 || n_ready !== 0 || n_stall !== 0) begin
      errors++;
      $display("FAIL start_gate got en=%0d ready=%0d stall=%0d want 0 0 0",
               n_en, n_ready, n_stall);
    end
    step();
    bus.ext_valid_i = 1'b0;
    bus.start_i = 1'b1;
    n_stall = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        step();
        if (i == 1) bus.start_i = 1'b0;
        if (drop) bus.cpu_req_i = 1'b0;
      end
      #1;
      if (bus.cpu_stall_o) n_stall++;
      if (bus.cpu_done_o && done_at < 0) begin done_at = i; drop = 1; end
    end
    checks++;
    if (done_at !== 3 || n_stall !== 1) begin
      errors++;
      $display("FAIL start_mid_busy got done_at=%0d stall=%0d want 3 1",
               done_at, n_stall);
    end
    bus.start_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_load();
    test_ext_write();
    test_tie();
    test_back_to_back();
    test_reset_mid_busy();
    test_start_gate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
